// File: rtl/multicycle_controller.sv
// Multicycle RISC-V subset controller: main FSM, ALU decode and immediate-select decode.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (illegal opcodes trap and set a sticky flag).
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal_instr
);

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_funct_alu;

    assign state = STATE_W'(r_state);

    // State register; async reset returns to FETCH immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // ALU operation selected by funct fields for R/I execute states
    always_comb begin
        w_funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  w_funct_alu = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_alu = ALU_ADD;
        endcase
    end

    // Immediate format select, decoded from opcode in every state
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next     = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      w_next = S_TRAP;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:  w_next = S_TRAP;
`else
            S_TRAP:  w_next = S_FETCH;
`endif
            default: w_next = S_FETCH;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_illegal;

    assign w_illegal = !((op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                         (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL));

    // Sticky flag set when an illegal opcode is decoded, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              r_illegal <= 1'b0;
        else if (r_state == S_DECODE && w_illegal) r_illegal <= 1'b1;
    end

    assign illegal_instr = r_illegal;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors with expected responses.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4, MWR = 4'd5;
    localparam logic [3:0] ER = 4'd6, EI = 4'd7, AW = 4'd8, BQ = 4'd9, JL = 4'd10, TR = 4'd11;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] ILL_S1 = TR, ILL_S2 = TR;
    localparam logic       ILL_FL = 1'b1, ILL_PI = 1'b0;
`else
    localparam logic [3:0] ILL_S1 = F, ILL_S2 = D;
    localparam logic       ILL_FL = 1'b0, ILL_PI = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       illegal_instr;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic [2:0] aluc;
        logic [1:0] imm;
        logic       ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .state(state), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // State-only outputs {AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB}
    function automatic logic [8:0] moore(input logic [3:0] s);
        case (s)
            F:       moore = {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10};
            D:       moore = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01};
            MA:      moore = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01};
            MR:      moore = {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            MW:      moore = {1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00};
            MWR:     moore = {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            ER:      moore = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00};
            EI:      moore = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01};
            AW:      moore = {1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
            BQ:      moore = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00};
            JL:      moore = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10};
            default: moore = 9'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus plus the response expected during that cycle
    task automatic cyc(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr, input logic rst,
                       input logic [3:0] es, input logic epcw, input logic eirw,
                       input logic [2:0] ealuc, input logic [1:0] eimm, input logic eill);
        exp_t e;
        @(posedge clk);
        #1;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr; reset = rst;
        e.st = es; e.pcw = epcw; e.irw = eirw; e.aluc = ealuc; e.imm = eimm; e.ill = eill;
        q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the scoreboard on the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", 16'(state), 16'(e.st));
            chk("moore_outputs", 16'({AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB}),
                16'(moore(e.st)));
            chk("PCWrite", 16'(PCWrite), 16'(e.pcw));
            chk("IRWrite", 16'(IRWrite), 16'(e.irw));
            chk("ALUControl", 16'(ALUControl), 16'(e.aluc));
            chk("ImmSrc", 16'(ImmSrc), 16'(e.imm));
            chk("illegal_instr", 16'(illegal_instr), 16'(e.ill));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        //   op      f3      f7    z     mr    rst   state pcw   irw   aluc    imm    ill
        cyc(OP_R,   3'b000, 1'b0, 1'b0, 1'b1, 1'b0, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        // add
        cyc(OP_R,   3'b000, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b000, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b000, 1'b0, 1'b0, 1'b1, 1'b1, ER, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b000, 1'b0, 1'b0, 1'b1, 1'b1, AW, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        // sub
        cyc(OP_R,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, ER, 1'b0, 1'b0, 3'b001, 2'b00, 1'b0);
        cyc(OP_R,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, AW, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        // addi with IR[30]=1 stays add
        cyc(OP_I,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, EI, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b000, 1'b1, 1'b0, 1'b1, 1'b1, AW, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        // slti
        cyc(OP_I,   3'b010, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b010, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b010, 1'b0, 1'b0, 1'b1, 1'b1, EI, 1'b0, 1'b0, 3'b101, 2'b00, 1'b0);
        cyc(OP_I,   3'b010, 1'b0, 1'b0, 1'b1, 1'b1, AW, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        // or
        cyc(OP_R,   3'b110, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b110, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b110, 1'b0, 1'b0, 1'b1, 1'b1, ER, 1'b0, 1'b0, 3'b011, 2'b00, 1'b0);
        cyc(OP_R,   3'b110, 1'b0, 1'b0, 1'b1, 1'b1, AW, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        // andi
        cyc(OP_I,   3'b111, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b111, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b111, 1'b0, 1'b0, 1'b1, 1'b1, EI, 1'b0, 1'b0, 3'b010, 2'b00, 1'b0);
        cyc(OP_I,   3'b111, 1'b0, 1'b0, 1'b1, 1'b1, AW, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        // lw with two wait cycles in MEMREAD
        cyc(OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, MA, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_LW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b1, MR, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_LW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b1, MR, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, MR, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, MW, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        // sw: fetch stalls once, then three wait cycles in MEMWRITE
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b1, F,  1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b01, 1'b0);
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, MA, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b1, MWR,1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b1, MWR,1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b1, MWR,1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        cyc(OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, 1'b1, MWR,1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        // beq taken, then not taken
        cyc(OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b10, 1'b0);
        cyc(OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b10, 1'b0);
        cyc(OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, BQ, 1'b1, 1'b0, 3'b001, 2'b10, 1'b0);
        cyc(OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b10, 1'b0);
        cyc(OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b10, 1'b0);
        cyc(OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, BQ, 1'b0, 1'b0, 3'b001, 2'b10, 1'b0);
        // jal
        cyc(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b11, 1'b0);
        cyc(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b11, 1'b0);
        cyc(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, JL, 1'b1, 1'b0, 3'b000, 2'b11, 1'b0);
        cyc(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, AW, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0);
        // addi aborted by reset dropping inside EXECUTEI, before the next clock edge
        cyc(OP_I,   3'b000, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b000, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b000, 1'b0, 1'b0, 1'b1, 1'b0, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_I,   3'b000, 1'b0, 1'b0, 1'b1, 1'b0, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        // illegal opcode
        cyc(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, D,  1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, ILL_S1, ILL_PI, ILL_PI, 3'b000, 2'b00, ILL_FL);
        cyc(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, ILL_S2, 1'b0, 1'b0, 3'b000, 2'b00, ILL_FL);
        cyc(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);
        cyc(OP_R,   3'b000, 1'b0, 1'b0, 1'b1, 1'b1, F,  1'b1, 1'b1, 3'b000, 2'b00, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
